shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//   Two requesters (A, B) share a single 32-bit shift unit. A round-robin
//   arbiter accepts one request at a time in IDLE. The request is shifted in
//   SHIFT and then presented in RESP until the consumer takes it.
//
//   Ports
//     clock, reset             sole clock; synchronous active-high reset
//     req_a_valid/_data/_shamt/_op, req_a_ready
//                              requester A handshake and operands
//                              (op: 0 = SLL, 1 = SRA)
//     req_b_*                  requester B, same meaning as req_a_*
//     resp_valid/_result/_id, resp_ready
//                              result handshake (id: 0 = A, 1 = B)
//     busy                     high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module shift_arbiter (
  input  logic        clock,
  input  logic        reset,

  input  logic        req_a_valid,
  input  logic [31:0] req_a_data,
  input  logic [4:0]  req_a_shamt,
  input  logic        req_a_op,
  output logic        req_a_ready,

  input  logic        req_b_valid,
  input  logic [31:0] req_b_data,
  input  logic [4:0]  req_b_shamt,
  input  logic        req_b_op,
  output logic        req_b_ready,

  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic        resp_id,
  input  logic        resp_ready,

  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // 1 = B was granted last, so A wins the next contention.
  logic        r_last_b;

  // Captured request.
  logic [31:0] r_data;
  logic [4:0]  r_shamt;
  logic        r_op;
  logic        r_id;

  // Registered response.
  logic [31:0] r_result;
  logic        r_resp_id;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept;
  logic [31:0] w_sll;
  logic signed [31:0] w_sra;
  logic [31:0] w_shift_result;

  // -------------------------------------------------------------------------
  // Arbitration. Grants are only possible in IDLE and never while reset is
  // high, so reset automatically beats any simultaneous transfer.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == ST_IDLE && !reset) begin
      if (req_a_valid && req_b_valid) begin
        w_grant_a = r_last_b;
        w_grant_b = !r_last_b;
      end else begin
        w_grant_a = req_a_valid;
        w_grant_b = req_b_valid;
      end
    end
  end

  assign w_accept = (req_a_valid && w_grant_a) || (req_b_valid && w_grant_b);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_next_state = ST_SHIFT;
      ST_SHIFT:                 w_next_state = ST_RESP;
      ST_RESP:  if (resp_ready) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_a_ready = w_grant_a;
    req_b_ready = w_grant_b;
    resp_valid  = (r_state == ST_RESP);
    busy        = (r_state != ST_IDLE);
    resp_result = r_result;
    resp_id     = r_resp_id;
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer: moves only on an accepted transfer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (w_accept) begin
      r_last_b <= w_grant_b;
    end
  end

  // -------------------------------------------------------------------------
  // Request capture.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: operand registers carry no reset; they are always written on
    // accept before SHIFT reads them, so their power-up value never escapes.
    if (w_accept) begin
      r_data  <= w_grant_b ? req_b_data  : req_a_data;
      r_shamt <= w_grant_b ? req_b_shamt : req_a_shamt;
      r_op    <= w_grant_b ? req_b_op    : req_a_op;
      r_id    <= w_grant_b;
    end
  end

  // -------------------------------------------------------------------------
  // Shared shift unit on the captured operands. The arithmetic shift keeps
  // the operand signed so bit 31 fills the vacated upper bits.
  // -------------------------------------------------------------------------
  assign w_sll          = r_data << r_shamt;
  assign w_sra          = $signed(r_data) >>> r_shamt;
  assign w_shift_result = r_op ? $unsigned(w_sra) : w_sll;

  // Result registered at the end of SHIFT and held through RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result  <= 32'h0;
      r_resp_id <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_result  <= w_shift_result;
      r_resp_id <= r_id;
    end
  end

endmodule
